// File: rtl/ahbl_apb_bridge_gen2_if.sv
// AHB-Lite slave / APB4 master signal bundle for the gen2 bridge.
// slave = bridge view, master = bus/environment view.
interface ahbl_apb_bridge_gen2_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 16
);
  logic                    HSEL;
  logic [ADDR_WIDTH-1:0]   HADDR;
  logic [1:0]              HTRANS;
  logic                    HWRITE;
  logic [2:0]              HSIZE;
  logic [DATA_WIDTH-1:0]   HWDATA;
  logic                    HREADYIN;
  logic [DATA_WIDTH-1:0]   HRDATA;
  logic                    HREADYOUT;
  logic                    HRESP;
  logic [NUM_SLAVES-1:0]   PSEL;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE,
    input  HWDATA, HREADYIN,
    output HRDATA, HREADYOUT, HRESP,
    output PSEL, PADDR, PENABLE, PWRITE,
    output PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE,
    output HWDATA, HREADYIN,
    input  HRDATA, HREADYOUT, HRESP,
    input  PSEL, PADDR, PENABLE, PWRITE,
    input  PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ahbl_apb_bridge_gen2.sv
// AHB-Lite slave to APB4 master bridge with one-hot selects,
// byte strobes, wait states, slave error and access timeout.
module ahbl_apb_bridge_gen2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 16,
  parameter int SLOT_LSB   = 8,
  parameter int SLOT_USED  = 16,
  parameter int TIMEOUT    = 256
) (
  input logic HCLK,
  input logic HRESET,
  ahbl_apb_bridge_gen2_if.slave bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int SLOT_W =
    (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETUP,
    ACCESS,
    ERR1,
    ERR2
  } state_t;

  state_t state;
  state_t state_nx;

  logic                  accept;
  logic                  can_accept;
  logic                  bad;
  logic                  timeout_hit;
  logic                  done_ok;
  logic                  done_err;
  logic [SLOT_W-1:0]     slot_in;
  logic [SLOT_W-1:0]     slot_q;
  logic [STRB_W-1:0]     strb_in;
  logic [STRB_W-1:0]     pstrb_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [DATA_WIDTH-1:0] hrdata_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  unused_htrans;

  assign unused_htrans = bus.HTRANS[0];

  generate
    if (NUM_SLAVES > 1) begin : g_slot
      assign slot_in = bus.HADDR[SLOT_LSB +: SLOT_W];
    end else begin : g_one
      assign slot_in = '0;
    end
  endgenerate

  assign accept =
    bus.HSEL & bus.HTRANS[1] & bus.HREADYIN;
  assign can_accept =
    (state == IDLE) || (state == ERR2);
  assign bad =
    (int'(slot_in) >= SLOT_USED) ||
    (int'(bus.HSIZE) > LANE_W);
  assign timeout_hit =
    (TIMEOUT > 0) && (cnt_q == CNT_LAST);
  assign done_ok = bus.PREADY & ~bus.PSLVERR;
  assign done_err =
    (bus.PREADY & bus.PSLVERR) | timeout_hit;

  // A lane is active when it shares the size-aligned block with HADDR.
  always_comb begin
    strb_in = '0;
    for (int i = 0; i < STRB_W; i++) begin
      strb_in[i] = bus.HWRITE &&
        ((i >> bus.HSIZE) ==
         (int'(bus.HADDR[LANE_W-1:0]) >> bus.HSIZE));
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, ERR2: begin
        if (accept) begin
          state_nx = bad ? ERR1 : LATCH;
        end else begin
          state_nx = IDLE;
        end
      end
      LATCH:  state_nx = SETUP;
      SETUP:  state_nx = ACCESS;
      ACCESS: begin
        if (done_ok) begin
          state_nx = IDLE;
        end else if (done_err) begin
          state_nx = ERR1;
        end
      end
      ERR1:    state_nx = ERR2;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      slot_q   <= '0;
      pstrb_q  <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (can_accept && accept) begin
        paddr_q  <= bus.HADDR;
        pwrite_q <= bus.HWRITE;
        slot_q   <= slot_in;
        pstrb_q  <= strb_in;
      end
      if (state == LATCH) begin
        pwdata_q <= bus.HWDATA;
      end
      if (state == ACCESS && done_ok && !pwrite_q) begin
        hrdata_q <= bus.PRDATA;
      end
      if (state == LATCH) begin
        cnt_q <= '0;
      end else if (state == ACCESS) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Selects decode straight from state so reset drops them immediately.
  assign bus.PSEL =
    (state == SETUP || state == ACCESS) ?
    (NUM_SLAVES'(1) << slot_q) : '0;
  assign bus.PENABLE   = (state == ACCESS);
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.HRDATA    = hrdata_q;
  assign bus.HREADYOUT =
    (state == IDLE) || (state == ERR2);
  assign bus.HRESP =
    (state == ERR1) || (state == ERR2);

endmodule

// File: tb/tb_ahbl_apb_bridge_gen2.sv
// Scoreboard bench for the gen2 AHB-Lite to APB bridge.
// APB setups are queued as observed and matched to expected entries.
module tb_ahbl_apb_bridge_gen2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahbl_apb_bridge_gen2_if #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(16)
  ) ifc ();

  ahbl_apb_bridge_gen2 #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(16),
    .SLOT_LSB(8), .SLOT_USED(4), .TIMEOUT(8)
  ) dut (
    .HCLK(clk),
    .HRESET(rst),
    .bus(ifc.slave)
  );

  typedef struct packed {
    logic [15:0] psel;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } apb_t;

  apb_t        exp_q[$];
  apb_t        got_q[$];
  logic [31:0] rd_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  int          cfg_wait  = 0;
  logic        cfg_err   = 1'b0;
  logic [31:0] cfg_rdata = 32'h0;
  int          wait_left = 0;
  logic        pready_r  = 1'b0;
  logic        pslverr_r = 1'b0;

  assign ifc.PREADY   = pready_r;
  assign ifc.PSLVERR  = pslverr_r;
  assign ifc.PRDATA   = cfg_rdata;
  assign ifc.HREADYIN = ifc.HREADYOUT;

  int          obs_waits;
  int          obs_pen;
  logic        obs_psel_any;
  logic        obs_done;
  logic        obs_last_resp;
  logic        obs_fin_resp;
  logic [31:0] obs_rdata;

  // APB slave: cfg_wait low-PREADY access cycles, then ready.
  always @(negedge clk) begin
    if (ifc.PSEL != 0 && !ifc.PENABLE) begin
      wait_left = cfg_wait;
      pready_r  = 1'b0;
      pslverr_r = 1'b0;
    end else if (ifc.PSEL != 0 && ifc.PENABLE) begin
      if (wait_left > 0) begin
        wait_left = wait_left - 1;
        pready_r  = 1'b0;
      end else begin
        pready_r  = 1'b1;
        pslverr_r = cfg_err;
      end
    end else begin
      pready_r  = 1'b0;
      pslverr_r = 1'b0;
    end
  end

  task automatic record_setup();
    apb_t g;
    g.psel  = ifc.PSEL;
    g.addr  = ifc.PADDR;
    g.write = ifc.PWRITE;
    g.wdata = ifc.PWDATA;
    g.strb  = ifc.PSTRB;
    got_q.push_back(g);
  endtask

  task automatic run_xfer(input logic [31:0] addr,
                          input logic write,
                          input logic [2:0] size,
                          input logic [31:0] wdata);
    obs_waits = 0; obs_pen = 0; obs_psel_any = 0;
    obs_done = 0; obs_last_resp = 0; obs_fin_resp = 0;
    @(posedge clk); #1;
    ifc.HSEL = 1'b1; ifc.HTRANS = 2'b10; ifc.HADDR = addr;
    ifc.HWRITE = write; ifc.HSIZE = size;
    @(posedge clk); #1;
    ifc.HSEL = 1'b0; ifc.HTRANS = 2'b00; ifc.HWDATA = wdata;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ifc.PSEL != 0 && !ifc.PENABLE) record_setup();
      if (ifc.PENABLE) obs_pen++;
      if (ifc.PSEL != 0) obs_psel_any = 1'b1;
      if (ifc.HREADYOUT) begin
        obs_done = 1'b1;
        obs_fin_resp = ifc.HRESP;
        obs_rdata = ifc.HRDATA;
        break;
      end
      obs_waits++;
      obs_last_resp = ifc.HRESP;
    end
  endtask

  task automatic test_reset();
    ifc.HSEL = 0; ifc.HTRANS = 0; ifc.HADDR = 0;
    ifc.HWRITE = 0; ifc.HSIZE = 0; ifc.HWDATA = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({ifc.PSEL, ifc.PENABLE} !== 17'h0)
      $display("FAIL rst_psel got %h/%b want 0/0", ifc.PSEL, ifc.PENABLE);
    else pass_cnt++;
    total_cnt++;
    if ({ifc.PADDR, ifc.PWDATA, ifc.PSTRB, ifc.PWRITE} !== 69'h0)
      $display("FAIL rst_apb got %h %h %h %b want zeros",
               ifc.PADDR, ifc.PWDATA, ifc.PSTRB, ifc.PWRITE);
    else pass_cnt++;
    total_cnt++;
    if (ifc.HRDATA !== 32'h0)
      $display("FAIL rst_hrdata got %h want 0", ifc.HRDATA);
    else pass_cnt++;
    total_cnt++;
    if ({ifc.HREADYOUT, ifc.HRESP} !== 2'b10)
      $display("FAIL rst_hresp got %b%b want 10", ifc.HREADYOUT, ifc.HRESP);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write();
    apb_t e, g;
    e = '{psel:16'h0008, addr:32'h304, write:1'b1,
          wdata:32'hA5A5_1234, strb:4'hF};
    exp_q.push_back(e);
    run_xfer(32'h304, 1'b1, 3'd2, 32'hA5A5_1234);
    total_cnt++;
    if (got_q.size() == 0) $display("FAIL wr_apb no setup seen");
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) $display("FAIL wr_apb got %h want %h", g, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_waits !== 3)
      $display("FAIL wr_waits got %0d want 3", obs_waits);
    else pass_cnt++;
    total_cnt++;
    if (obs_done !== 1'b1 || obs_fin_resp !== 1'b0)
      $display("FAIL wr_resp got done=%b resp=%b want 1 0", obs_done, obs_fin_resp);
    else pass_cnt++;
  endtask

  task automatic test_read_wait();
    apb_t e, g;
    logic [31:0] r;
    cfg_wait = 3; cfg_rdata = 32'hDEAD_BEEF;
    e = '{psel:16'h0004, addr:32'h200, write:1'b0,
          wdata:32'h0, strb:4'h0};
    exp_q.push_back(e);
    rd_q.push_back(32'hDEAD_BEEF);
    run_xfer(32'h200, 1'b0, 3'd2, 32'h0);
    total_cnt++;
    if (got_q.size() == 0) $display("FAIL rd_apb no setup seen");
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) $display("FAIL rd_apb got %h want %h", g, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_waits !== 6)
      $display("FAIL rd_waits got %0d want 6", obs_waits);
    else pass_cnt++;
    total_cnt++;
    if (obs_pen !== 4)
      $display("FAIL rd_penable got %0d want 4", obs_pen);
    else pass_cnt++;
    r = rd_q.pop_front();
    total_cnt++;
    if (obs_done !== 1'b1 || obs_rdata !== r)
      $display("FAIL rd_data got %h want %h", obs_rdata, r);
    else pass_cnt++;
    cfg_wait = 0; cfg_rdata = 32'h1357_9BDF;
  endtask

  task automatic test_strb();
    apb_t e, g;
    e = '{psel:16'h0002, addr:32'h102, write:1'b1,
          wdata:32'h00AB_0000, strb:4'b0100};
    exp_q.push_back(e);
    run_xfer(32'h102, 1'b1, 3'd0, 32'h00AB_0000);
    total_cnt++;
    if (got_q.size() == 0) $display("FAIL strb_b no setup seen");
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) $display("FAIL strb_b got %h want %h", g, e);
      else pass_cnt++;
    end
    e = '{psel:16'h0002, addr:32'h106, write:1'b1,
          wdata:32'hBEEF_0000, strb:4'b1100};
    exp_q.push_back(e);
    run_xfer(32'h106, 1'b1, 3'd1, 32'hBEEF_0000);
    total_cnt++;
    if (got_q.size() == 0) $display("FAIL strb_h no setup seen");
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) $display("FAIL strb_h got %h want %h", g, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_rdata !== 32'hDEAD_BEEF)
      $display("FAIL hrdata_hold got %h want deadbeef", obs_rdata);
    else pass_cnt++;
  endtask

  task automatic test_slverr();
    apb_t e, g;
    cfg_err = 1'b1;
    e = '{psel:16'h0002, addr:32'h104, write:1'b1,
          wdata:32'h1111_2222, strb:4'hF};
    exp_q.push_back(e);
    run_xfer(32'h104, 1'b1, 3'd2, 32'h1111_2222);
    total_cnt++;
    if (got_q.size() == 0) $display("FAIL err_apb no setup seen");
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) $display("FAIL err_apb got %h want %h", g, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_waits !== 4 || obs_last_resp !== 1'b1)
      $display("FAIL err_first got waits=%0d resp=%b want 4 1", obs_waits, obs_last_resp);
    else pass_cnt++;
    total_cnt++;
    if (obs_done !== 1'b1 || obs_fin_resp !== 1'b1)
      $display("FAIL err_second got done=%b resp=%b want 1 1", obs_done, obs_fin_resp);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({ifc.HREADYOUT, ifc.HRESP} !== 2'b10)
      $display("FAIL err_idle got %b%b want 10", ifc.HREADYOUT, ifc.HRESP);
    else pass_cnt++;
    cfg_err = 1'b0;
  endtask

  task automatic test_bad();
    run_xfer(32'h500, 1'b1, 3'd2, 32'h5555_5555);
    total_cnt++;
    if (obs_psel_any !== 1'b0 || got_q.size() != 0)
      $display("FAIL bad_slot_psel got %b want 0", obs_psel_any);
    else pass_cnt++;
    total_cnt++;
    if (obs_waits !== 1 || obs_last_resp !== 1'b1 || obs_fin_resp !== 1'b1)
      $display("FAIL bad_slot_resp got w=%0d r=%b%b want 1 11",
               obs_waits, obs_last_resp, obs_fin_resp);
    else pass_cnt++;
    run_xfer(32'h100, 1'b1, 3'd3, 32'h6666_6666);
    total_cnt++;
    if (obs_psel_any !== 1'b0 || got_q.size() != 0)
      $display("FAIL bad_size_psel got %b want 0", obs_psel_any);
    else pass_cnt++;
    total_cnt++;
    if (obs_waits !== 1 || obs_last_resp !== 1'b1 || obs_fin_resp !== 1'b1)
      $display("FAIL bad_size_resp got w=%0d r=%b%b want 1 11",
               obs_waits, obs_last_resp, obs_fin_resp);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    apb_t e, g;
    cfg_wait = 1000;
    e = '{psel:16'h0008, addr:32'h300, write:1'b0,
          wdata:32'h0, strb:4'h0};
    exp_q.push_back(e);
    run_xfer(32'h300, 1'b0, 3'd2, 32'h0);
    total_cnt++;
    if (got_q.size() == 0) $display("FAIL to_apb no setup seen");
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e) $display("FAIL to_apb got %h want %h", g, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_pen !== 8)
      $display("FAIL to_penable got %0d want 8", obs_pen);
    else pass_cnt++;
    total_cnt++;
    if (obs_waits !== 11 || obs_last_resp !== 1'b1 || obs_fin_resp !== 1'b1)
      $display("FAIL to_resp got w=%0d r=%b%b want 11 11",
               obs_waits, obs_last_resp, obs_fin_resp);
    else pass_cnt++;
    total_cnt++;
    if (obs_rdata !== 32'hDEAD_BEEF)
      $display("FAIL to_hrdata got %h want deadbeef", obs_rdata);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    cfg_wait = 1000;
    @(posedge clk); #1;
    ifc.HSEL = 1'b1; ifc.HTRANS = 2'b10; ifc.HADDR = 32'h100;
    ifc.HWRITE = 1'b1; ifc.HSIZE = 3'd2;
    @(posedge clk); #1;
    ifc.HSEL = 1'b0; ifc.HTRANS = 2'b00; ifc.HWDATA = 32'h7777_0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.PENABLE) begin
        seen = 1'b1;
        break;
      end
    end
    total_cnt++;
    if (seen !== 1'b1) $display("FAIL rstmid_access got 0 want 1");
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({ifc.PSEL, ifc.PENABLE, ifc.HREADYOUT, ifc.HRESP} !== 19'b10)
      $display("FAIL rstmid_clear got psel=%h en=%b rdy=%b resp=%b want 0 0 1 0",
               ifc.PSEL, ifc.PENABLE, ifc.HREADYOUT, ifc.HRESP);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    cfg_wait = 0;
  endtask

  task automatic test_back_to_back();
    apb_t e, g;
    int   w;
    logic done;
    e = '{psel:16'h0008, addr:32'h308, write:1'b1,
          wdata:32'h0102_0304, strb:4'hF};
    exp_q.push_back(e);
    @(posedge clk); #1;
    ifc.HSEL = 1'b1; ifc.HTRANS = 2'b10; ifc.HADDR = 32'h308;
    ifc.HWRITE = 1'b1; ifc.HSIZE = 3'd2;
    @(posedge clk); #1;
    ifc.HSEL = 1'b0; ifc.HTRANS = 2'b00; ifc.HWDATA = 32'h0102_0304;
    w = 0; done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.PSEL != 0 && !ifc.PENABLE) record_setup();
      if (ifc.HREADYOUT) begin
        done = 1'b1;
        break;
      end
      w++;
    end
    total_cnt++;
    if (done !== 1'b1 || w !== 3)
      $display("FAIL b2b_first got done=%b waits=%0d want 1 3", done, w);
    else pass_cnt++;
    // Second address phase in the completion cycle of the first.
    ifc.HSEL = 1'b1; ifc.HTRANS = 2'b10; ifc.HADDR = 32'h10C;
    ifc.HWRITE = 1'b1; ifc.HSIZE = 3'd2;
    e = '{psel:16'h0002, addr:32'h10C, write:1'b1,
          wdata:32'hCAFE_F00D, strb:4'hF};
    exp_q.push_back(e);
    @(posedge clk); #1;
    ifc.HSEL = 1'b0; ifc.HTRANS = 2'b00; ifc.HWDATA = 32'hCAFE_F00D;
    @(negedge clk);
    total_cnt++;
    if (ifc.PSEL !== 16'h0 || ifc.HREADYOUT !== 1'b0)
      $display("FAIL b2b_latch got psel=%h rdy=%b want 0 0", ifc.PSEL, ifc.HREADYOUT);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (ifc.PSEL !== 16'h0002 || ifc.PENABLE !== 1'b0)
      $display("FAIL b2b_setup got psel=%h en=%b want 0002 0", ifc.PSEL, ifc.PENABLE);
    else pass_cnt++;
    if (ifc.PSEL != 0 && !ifc.PENABLE) record_setup();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.HREADYOUT) break;
    end
    for (int k = 0; k < 2; k++) begin
      total_cnt++;
      if (got_q.size() == 0) $display("FAIL b2b_apb%0d no setup seen", k);
      else begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        if (g !== e) $display("FAIL b2b_apb%0d got %h want %h", k, g, e);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_strb();
    test_slverr();
    test_bad();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
